// File: rtl/vec_length_iter.sv
// vec_length_iter: iterative Euclidean length (or squared length) of a 2-D/3-D fixed-point vector
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input transaction present (accepted only in IDLE)
//   in_ready   high only while IDLE
//   x, y, z    signed N-bit components, FRAC fractional bits (z ignored when DIM=2)
//   sq_mode    1 = squared length, 0 = length; captured with the components
//   out_valid  result present; held until out_ready
//   out_ready  consumer accepts the result (ignored unless a result is present)
//   length     unsigned N-bit result, FRAC fractional bits
//   sat        squared-length result was clipped to all ones
module vec_length_iter #(
    parameter int N    = 32,
    parameter int FRAC = 8,
    parameter int DIM  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] z,
    input  logic         sq_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] length,
    output logic         sat
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;
    state_t state, state_nx;

    logic [N-1:0]          xr, yr, zr;
    logic                  mode;
    logic [2*N-1:0]        rad;
    logic [N+1:0]          rem;
    logic [N-1:0]          root;
    logic [CW-1:0]         cnt;

    logic signed [2*N-1:0] xe, ye, ze;
    logic [2*N-1:0]        sum;
    logic [N+3:0]          rem_sh, trial;
    logic                  ge;
    logic [2*N-FRAC-1:0]   sq;
    logic                  ovf;

    // Sign-extend before squaring so -2^(N-1) squares to +2^(2N-2).
    assign xe  = {{N{xr[N-1]}}, xr};
    assign ye  = {{N{yr[N-1]}}, yr};
    assign ze  = {{N{zr[N-1]}}, zr};
    assign sum = $unsigned(xe * xe + ye * ye + ze * ze);

    // Restoring square-root step: bring down the next two radicand bits and
    // try subtracting (root*4 + 1). The remainder before shifting never
    // exceeds N bits, so the stored low N+2 bits of the difference are exact.
    assign rem_sh = {rem, rad[2*N-1:2*N-2]};
    assign trial  = {2'b00, root, 2'b01};
    assign ge     = rem_sh >= trial;

    assign sq  = rad[2*N-1:FRAC];
    assign ovf = |sq[2*N-FRAC-1:N];

    assign in_ready = state == IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? SQUARE : IDLE;
            SQUARE:  state_nx = mode ? DONE : ROOT;
            ROOT:    state_nx = cnt == '0 ? DONE : ROOT;
            DONE:    state_nx = out_valid && out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // The first DONE cycle registers the formatted result; out_valid rises
    // after it and out_ready is only honoured once out_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            mode      <= 1'b0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            length    <= '0;
            sat       <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                xr   <= x;
                yr   <= y;
                zr   <= DIM == 2 ? '0 : z;
                mode <= sq_mode;
            end
            if (state == SQUARE) begin
                rad  <= sum;
                rem  <= '0;
                root <= '0;
                cnt  <= CW'(N - 1);
            end
            if (state == ROOT) begin
                rad  <= rad << 2;
                rem  <= ge ? rem_sh[N+1:0] - trial[N+1:0] : rem_sh[N+1:0];
                root <= {root[N-2:0], ge};
                cnt  <= cnt - 1'b1;
            end
            if (state == DONE && !out_valid) begin
                out_valid <= 1'b1;
                length    <= mode ? (ovf ? '1 : sq[N-1:0]) : root;
                sat       <= mode & ovf;
            end
            if (state == DONE && out_valid && out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vec_length_iter.sv
// tb_vec_length_iter: directed scoreboard bench for vec_length_iter (DIM=3 and DIM=2 builds)
module tb_vec_length_iter;
    localparam int N     = 32;
    localparam int FRAC  = 8;
    localparam int LAT_R = N + 2;
    localparam int LAT_S = 2;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, in_valid2 = 1'b0, sq_mode = 1'b0, out_ready = 1'b0;
    logic [N-1:0] x = '0, y = '0, z = '0;
    logic         in_ready, out_valid, sat, in_ready2, out_valid2, sat2;
    logic [N-1:0] length, length2;

    int checks = 0, passes = 0, fails = 0;

    typedef struct {
        logic [N-1:0] len;
        logic         sat;
        int           lat;
    } exp_t;
    exp_t sb[$];

    vec_length_iter #(.N(N), .FRAC(FRAC), .DIM(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z), .sq_mode(sq_mode), .out_valid(out_valid),
        .out_ready(out_ready), .length(length), .sat(sat)
    );

    vec_length_iter #(.N(N), .FRAC(FRAC), .DIM(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .x(x), .y(y), .z(z), .sq_mode(sq_mode), .out_valid(out_valid2),
        .out_ready(out_ready), .length(length2), .sat(sat2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Integer square root by binary search (independent of the digit recurrence).
    function automatic logic [N-1:0] isqrt(input logic [2*N-1:0] r);
        logic [N:0]     lo, hi, mid;
        logic [2*N+1:0] m2;
        lo = '0;
        hi = {1'b0, {N{1'b1}}};
        while (lo < hi) begin
            mid = (lo + hi + 1) >> 1;
            m2  = {{(N+1){1'b0}}, mid} * {{(N+1){1'b0}}, mid};
            if (m2 <= {2'b00, r}) lo = mid;
            else hi = mid - 1;
        end
        return lo[N-1:0];
    endfunction

    function automatic void push_exp(input logic [N-1:0] len, input logic s, input int lat);
        exp_t e;
        e.len = len;
        e.sat = s;
        e.lat = lat;
        sb.push_back(e);
    endfunction

    function automatic void push_model(input logic [N-1:0] a, b, c, input logic sm);
        logic signed [2*N+1:0] ea, eb, ec;
        logic [2*N+1:0]        r, s;
        ea = $signed(a);
        eb = $signed(b);
        ec = $signed(c);
        r  = ea * ea + eb * eb + ec * ec;
        s  = r >> FRAC;
        if (sm) push_exp(|s[2*N+1:N] ? '1 : s[N-1:0], |s[2*N+1:N], LAT_S);
        else    push_exp(isqrt(r[2*N-1:0]), 1'b0, LAT_R);
    endfunction

    task automatic send(input logic [N-1:0] a, b, c, input logic sm, input bit d2);
        @(negedge clk);
        x = a; y = b; z = c; sq_mode = sm;
        if (d2) in_valid2 = 1'b1;
        else in_valid = 1'b1;
        check("in_ready_accept", d2 ? in_ready2 : in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_valid2 = 1'b0;
        x = $urandom; y = $urandom; z = $urandom; sq_mode = ~sm;
        @(negedge clk);
    endtask

    task automatic collect(input bit d2, input int hold, input bit orp);
        exp_t         e;
        int           lat = 0;
        logic [N-1:0] len0;
        logic         sat0;
        e = sb.pop_front();
        while (!(d2 ? out_valid2 : out_valid) && lat < 200) begin
            out_ready = orp && lat < 5;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        check("latency", lat, e.lat);
        check("length", d2 ? length2 : length, e.len);
        check("sat", d2 ? sat2 : sat, e.sat);
        check("in_ready_busy", d2 ? in_ready2 : in_ready, 1'b0);
        len0 = d2 ? length2 : length;
        sat0 = d2 ? sat2 : sat;
        repeat (hold) begin
            x = $urandom; y = $urandom; z = $urandom; sq_mode = $urandom;
            if (!d2) in_valid = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            check("hold_valid", d2 ? out_valid2 : out_valid, 1'b1);
            check("hold_length", d2 ? length2 : length, len0);
            check("hold_sat", d2 ? sat2 : sat, sat0);
            check("hold_in_ready", d2 ? in_ready2 : in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_clear", d2 ? out_valid2 : out_valid, 1'b0);
        check("in_ready_idle", d2 ? in_ready2 : in_ready, 1'b1);
    endtask

    initial begin
        logic [N-1:0] ra, rb, rc;
        logic         rm;
        int           seen;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_length", length, '0);
        check("rst_sat", sat, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        push_exp(32'h500, 1'b0, LAT_R);
        send(32'h300, 32'h400, 32'h0, 1'b0, 1'b0);
        collect(1'b0, 0, 1'b0);
        push_exp(32'h300, 1'b0, LAT_R);
        send(32'h100, 32'h200, 32'h200, 1'b0, 1'b0);
        collect(1'b0, 0, 1'b0);
        push_exp(32'h1B12, 1'b0, LAT_R);
        send(32'h1400, 32'h1200, 32'h300, 1'b0, 1'b0);
        collect(1'b0, 0, 1'b0);
        push_exp(32'h500, 1'b0, LAT_R);
        send(32'hFFFF_FD00, 32'hFFFF_FC00, 32'h0, 1'b0, 1'b0);
        collect(1'b0, 0, 1'b1);
        push_exp(32'h0, 1'b0, LAT_R);
        send(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        collect(1'b0, 0, 1'b0);
        push_exp(32'h8000_0000, 1'b0, LAT_R);
        send(32'h8000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
        collect(1'b0, 0, 1'b0);
        push_model(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
        collect(1'b0, 0, 1'b0);

        push_exp(32'h1900, 1'b0, LAT_S);
        send(32'h300, 32'h400, 32'h0, 1'b1, 1'b0);
        collect(1'b0, 10, 1'b0);
        push_exp(32'hFFFF_FFFF, 1'b1, LAT_S);
        send(32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b0);
        collect(1'b0, 0, 1'b0);
        push_model(32'h8000_0000, 32'h0, 32'h0, 1'b1);
        send(32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
        collect(1'b0, 0, 1'b0);
        push_model(32'h0, 32'h0, 32'h0001_0000, 1'b1);
        send(32'h0, 32'h0, 32'h0001_0000, 1'b1, 1'b0);
        collect(1'b0, 0, 1'b0);

        repeat (6) begin
            ra = $urandom; rb = $urandom; rc = $urandom; rm = $urandom;
            if ($urandom_range(1)) begin
                ra = ra >>> 12; rb = rb >>> 12; rc = rc >>> 12;
            end
            push_model(ra, rb, rc, rm);
            send(ra, rb, rc, rm, 1'b0);
            collect(1'b0, 0, 1'b0);
        end

        send(32'h300, 32'h400, 32'h0, 1'b0, 1'b0);
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_in_ready", in_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_output", seen, 0);
        push_exp(32'h500, 1'b0, LAT_R);
        send(32'h300, 32'h400, 32'h0, 1'b0, 1'b0);
        collect(1'b0, 0, 1'b0);

        push_exp(32'h500, 1'b0, LAT_R);
        send(32'h300, 32'h400, 32'h6300, 1'b0, 1'b1);
        collect(1'b1, 0, 1'b0);
        push_exp(32'h1900, 1'b0, LAT_S);
        send(32'h300, 32'h400, 32'h6300, 1'b1, 1'b1);
        collect(1'b1, 3, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
